// File: rtl/fdc_sd_arbiter_if.sv
// ---------------------------------------------------------------------------
// fdc_sd_arbiter_if
//
// Shared MiSTer SD block port, as seen between the floppy-controller arbiter
// (master) and the top-level hps_io SD channel (slave).
//
// Signals
//   sd_lba       master -> slave  32  block address of the transfer
//   sd_rd        master -> slave   1  read request (level)
//   sd_wr        master -> slave   1  write request (level)
//   sd_buff_din  master -> slave   8  buffer data for SD writes
//   sd_ack       slave  -> master  1  transfer acknowledge
//   sd_buff_wr   slave  -> master  1  buffer write strobe
//
// Handshake: sd_rd/sd_wr act as "valid" and sd_ack as "ready". The master
// raises exactly one of sd_rd/sd_wr together with a stable sd_lba and holds
// them until sd_ack is sampled high; it then drops the request while the
// slave keeps sd_ack high for the whole data phase. The transfer is complete
// on the first cycle sd_ack is sampled low again. sd_buff_wr and
// sd_buff_din are only meaningful while sd_ack is high.
// ---------------------------------------------------------------------------
interface fdc_sd_arbiter_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        output sd_buff_din,
        input  sd_ack,
        input  sd_buff_wr
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        input  sd_buff_din,
        output sd_ack,
        output sd_buff_wr
    );
endinterface

// File: rtl/fdc_sd_arbiter.sv
// ---------------------------------------------------------------------------
// fdc_sd_arbiter
//
// Shares one MiSTer SD block port between the four per-drive WD1793
// channels. Pending drives are granted round-robin, one transfer at a time;
// while a transfer is in flight ack and buffer-write strobes are steered to
// the granted drive only and its buffer data is forwarded to the SD port.
//
// Ports
//   CLK           in   1      system clock (posedge)
//   RESET_N       in   1      asynchronous active-low reset
//   req_lba       in   4x32   per-drive LBA
//   req_rd        in   4      per-drive read request (level, held until ack)
//   req_wr        in   4      per-drive write request (level, held until ack)
//   req_ack       out  4      per-drive ack (combinational)
//   req_buff_wr   out  4      per-drive gated buffer write (combinational)
//   req_buff_din  in   4x8    per-drive buffer read data
//   sd            master modport of fdc_sd_arbiter_if (shared SD port)
//   grant         out  2      granted / last granted drive
//   busy          out  1      high whenever the FSM is not idle
//   timeout_err   out  1      one-cycle pulse when an ISSUE timeout aborts
//   dbg_state     out  2      current FSM state for observation
//
// Parameter
//   TIMEOUT  cycles to wait in ISSUE for sd_ack before aborting (0 = never)
// ---------------------------------------------------------------------------
module fdc_sd_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [3:0][31:0] req_lba,
    input  logic [3:0]       req_rd,
    input  logic [3:0]       req_wr,
    output logic [3:0]       req_ack,
    output logic [3:0]       req_buff_wr,
    input  logic [3:0][7:0]  req_buff_din,
    fdc_sd_arbiter_if.master sd,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             timeout_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] lba_q, lba_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        terr_q, terr_d;
    logic [23:0] cnt_q, cnt_d;

    logic [3:0]  pending;
    logic        found;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic        active;

    assign pending = req_rd | req_wr;

    // Round-robin scan starting at rr: first pending drive wins.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = rr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + k[1:0];
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            rr_q    <= 2'd0;
            grant_q <= 2'd0;
            lba_q   <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    lba_d   = req_lba[pick];
                    // A drive asserting both read and write is treated as a write.
                    wr_d    = req_wr[pick];
                    rd_d    = !req_wr[pick];
                    cnt_d   = 24'd0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 24'd1;
                if (sd.sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_XFER;
                end else if (!pending[grant_q]) begin
                    // Drive withdrew before the SD side answered.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_DONE;
                end else if ((TIMEOUT != 24'd0) && (cnt_q == TIMEOUT - 24'd1)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_XFER: begin
                // Request drops are ignored here; only the ack falling ends it.
                if (!sd.sd_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_d    = grant_q + 2'd1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign active = (state_q == ST_ISSUE) || (state_q == ST_XFER);

    always_comb begin
        req_ack     = 4'b0000;
        req_buff_wr = 4'b0000;
        if (active) begin
            req_ack[grant_q]     = sd.sd_ack;
            req_buff_wr[grant_q] = sd.sd_buff_wr;
        end
    end

    assign sd.sd_lba      = lba_q;
    assign sd.sd_rd       = rd_q;
    assign sd.sd_wr       = wr_q;
    assign sd.sd_buff_din = req_buff_din[grant_q];

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

endmodule
